// File: rtl/jtframe_i2s_pkg.sv
// jtframe_i2s_pkg: shared helpers for the I2S/TDM transmitter.
//   frame_bits - serial bits per frame (channels * slot width)
//   cnt_w      - counter width able to hold 0..n-1 (never below 1)
//   bcnt_w     - width of the frame bit counter
//   mode_of    - framing mode implied by the channel count
package jtframe_i2s_pkg;

    typedef enum logic {I2S_STEREO, I2S_TDM} i2s_mode_e;

    function automatic int frame_bits(input int channels, input int slot_w);
        return channels * slot_w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bcnt_w(input int channels, input int slot_w);
        return cnt_w(frame_bits(channels, slot_w));
    endfunction

    function automatic i2s_mode_e mode_of(input int channels);
        return (channels > 2) ? I2S_TDM : I2S_STEREO;
    endfunction

endpackage

// File: rtl/jtframe_i2s_clkgen.sv
// jtframe_i2s_clkgen: free-running MCLK and SCLK dividers from clk_sys.
// Ports:
//   clk_sys   in  system clock
//   rst       in  asynchronous active-high reset
//   mclk      out master clock, toggles every MCLK_HALF cycles
//   sclk      out bit clock, toggles every SCLK_HALF cycles (first edge rises)
//   sclk_fall out high in the cycle at whose end sclk is registered to 0
module jtframe_i2s_clkgen #(
    parameter int unsigned SCLK_HALF = 2,
    parameter int unsigned MCLK_HALF = 1
) (
    input  logic clk_sys,
    input  logic rst,
    output logic mclk,
    output logic sclk,
    output logic sclk_fall
);
    import jtframe_i2s_pkg::*;

    localparam int MW = cnt_w(MCLK_HALF);
    localparam int SW = cnt_w(SCLK_HALF);

    logic [MW-1:0] mclk_cnt;
    logic [SW-1:0] sclk_cnt;
    logic          mclk_tick;
    logic          sclk_tick;

    always_comb begin
        mclk_tick = (mclk_cnt == MW'(MCLK_HALF - 1));
        sclk_tick = (sclk_cnt == SW'(SCLK_HALF - 1));
        sclk_fall = sclk_tick & sclk;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            mclk_cnt <= '0;
            sclk_cnt <= '0;
            mclk     <= 1'b0;
            sclk     <= 1'b0;
        end else begin
            mclk_cnt <= mclk_tick ? '0 : mclk_cnt + 1'b1;
            sclk_cnt <= sclk_tick ? '0 : sclk_cnt + 1'b1;
            if (mclk_tick) mclk <= ~mclk;
            if (sclk_tick) sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/jtframe_i2s_tx.sv
// jtframe_i2s_tx: parallel sound channels to I2S (stereo) or TDM serial audio.
// Ports:
//   clk_sys     in  system clock
//   rst         in  asynchronous active-high reset
//   snd         in  CHANNELS*SAMPLE_W packed samples, channel 0 in the LSBs
//   mute        in  transmit zero samples (sampled at frame wrap only)
//   sample_ack  out one-cycle pulse when snd is captured
//   frame_start out one-cycle pulse at the start of each frame's bit 0
//   MCLK        out master clock
//   SCLK        out bit clock
//   LRCLK       out word select (stereo) or frame sync (TDM)
//   SDIN        out serial data, MSB first, changes on SCLK falls
// Build option: define JTFRAME_I2S_LEFTJ_EN for left-justified timing
// (no one-bit data delay, TDM sync on bit 0, stereo LRCLK high for slot 0).
module jtframe_i2s_tx #(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 16,
    parameter bit          SIGNED_SND = 1'b1,
    parameter int unsigned SCLK_HALF  = 2,
    parameter int unsigned MCLK_HALF  = 1
) (
    input  logic                         clk_sys,
    input  logic                         rst,
    input  logic [CHANNELS*SAMPLE_W-1:0] snd,
    input  logic                         mute,
    output logic                         sample_ack,
    output logic                         frame_start,
    output logic                         MCLK,
    output logic                         SCLK,
    output logic                         LRCLK,
    output logic                         SDIN
);
    import jtframe_i2s_pkg::*;

    localparam int        FB   = frame_bits(CHANNELS, SLOT_W);
    localparam int        BW   = bcnt_w(CHANNELS, SLOT_W);
    localparam i2s_mode_e MODE = mode_of(CHANNELS);

`ifdef JTFRAME_I2S_LEFTJ_EN
    localparam bit LEFTJ = 1'b1;
`else
    localparam bit LEFTJ = 1'b0;
`endif

    logic sclk_fall;

    jtframe_i2s_clkgen #(
        .SCLK_HALF (SCLK_HALF),
        .MCLK_HALF (MCLK_HALF)
    ) u_clkgen (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .mclk      (MCLK),
        .sclk      (SCLK),
        .sclk_fall (sclk_fall)
    );

    // Frame vectors hold frame bit 0 in the MSB so shifting left walks the frame.
    logic [FB-1:0]       conv;
    logic [SAMPLE_W-1:0] smp;

    always_comb begin
        conv = '0;
        smp  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            smp = snd[k*SAMPLE_W +: SAMPLE_W];
            if (!SIGNED_SND) smp[SAMPLE_W-1] = ~smp[SAMPLE_W-1];
            conv[FB-1-k*SLOT_W -: SAMPLE_W] = smp;
        end
        if (mute) conv = '0;
    end

    logic [BW-1:0] bcnt, bcnt_nx;
    logic [FB-1:0] shadow, shadow_nx;
    logic [FB-1:0] shift, shift_nx;
    logic          sdin_nx, lrclk_nx, wrap;

    // The shadow adds one frame of latency: a capture at wrap k is sent after wrap k+1.
    always_comb begin
        wrap      = sclk_fall && (bcnt == BW'(FB - 1));
        bcnt_nx   = bcnt;
        shadow_nx = shadow;
        shift_nx  = shift;
        sdin_nx   = SDIN;
        lrclk_nx  = LRCLK;
        if (sclk_fall) begin
            bcnt_nx = wrap ? '0 : bcnt + 1'b1;
            if (wrap) begin
                shadow_nx = conv;
                if (LEFTJ) begin
                    sdin_nx  = shadow[FB-1];
                    shift_nx = shadow << 1;
                end else begin
                    // Last bit of the outgoing frame goes out during the new bit 0.
                    sdin_nx  = shift[FB-1];
                    shift_nx = shadow;
                end
            end else begin
                sdin_nx  = shift[FB-1];
                shift_nx = shift << 1;
            end
            if (MODE == I2S_STEREO) begin
                lrclk_nx = (bcnt_nx >= BW'(SLOT_W)) ^ LEFTJ;
            end else begin
                lrclk_nx = LEFTJ ? (bcnt_nx == '0) : (bcnt_nx == BW'(FB - 1));
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            bcnt        <= '0;
            shadow      <= '0;
            shift       <= '0;
            SDIN        <= 1'b0;
            LRCLK       <= 1'b0;
            sample_ack  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            bcnt        <= bcnt_nx;
            shadow      <= shadow_nx;
            shift       <= shift_nx;
            SDIN        <= sdin_nx;
            LRCLK       <= lrclk_nx;
            sample_ack  <= wrap;
            frame_start <= wrap;
        end
    end

endmodule

// File: tb/tb_jtframe_i2s_tx.sv
// Bench for jtframe_i2s_tx: three instances (stereo signed, stereo unsigned,
// 4-channel TDM 24-in-32) checked against a frame-level reference model.
module tb_jtframe_i2s_tx;

`ifdef JTFRAME_I2S_LEFTJ_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif
    localparam int OFF = LJ ? 0 : 1;

    logic        clk_sys;
    logic        rst;
    logic [31:0] snd0, snd1;
    logic [95:0] snd2;
    logic [2:0]  mute_v;
    logic [2:0]  mclk_v, sclk_v, lr_v, sd_v, ack_v, fs_v;

    int checks;
    int failures;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    jtframe_i2s_tx u_d0 (
        .clk_sys(clk_sys), .rst(rst), .snd(snd0), .mute(mute_v[0]),
        .sample_ack(ack_v[0]), .frame_start(fs_v[0]), .MCLK(mclk_v[0]),
        .SCLK(sclk_v[0]), .LRCLK(lr_v[0]), .SDIN(sd_v[0])
    );

    jtframe_i2s_tx #(.SIGNED_SND(1'b0)) u_d1 (
        .clk_sys(clk_sys), .rst(rst), .snd(snd1), .mute(mute_v[1]),
        .sample_ack(ack_v[1]), .frame_start(fs_v[1]), .MCLK(mclk_v[1]),
        .SCLK(sclk_v[1]), .LRCLK(lr_v[1]), .SDIN(sd_v[1])
    );

    jtframe_i2s_tx #(.CHANNELS(4), .SAMPLE_W(24), .SLOT_W(32)) u_d2 (
        .clk_sys(clk_sys), .rst(rst), .snd(snd2), .mute(mute_v[2]),
        .sample_ack(ack_v[2]), .frame_start(fs_v[2]), .MCLK(mclk_v[2]),
        .SCLK(sclk_v[2]), .LRCLK(lr_v[2]), .SDIN(sd_v[2])
    );

    // Per-instance configuration
    function automatic int p_ch(input int d);     return (d == 2) ? 4 : 2;   endfunction
    function automatic int p_sw(input int d);     return (d == 2) ? 24 : 16; endfunction
    function automatic int p_sl(input int d);     return (d == 2) ? 32 : 16; endfunction
    function automatic bit p_signed(input int d); return d != 1;             endfunction
    function automatic int p_fb(input int d);     return p_ch(d) * p_sl(d);  endfunction

    // Frame as transmitted, indexed by frame bit number (0 = slot 0 MSB).
    function automatic logic [255:0] model_frame(input int d, input logic [95:0] s,
                                                 input logic m);
        logic [255:0] f;
        logic [95:0]  sh;
        logic [31:0]  smp;
        int sw, sl, ch, pos;
        f  = '0;
        sw = p_sw(d);
        sl = p_sl(d);
        if (!m) begin
            for (int i = 0; i < p_fb(d); i++) begin
                ch  = i / sl;
                pos = i % sl;
                sh  = s >> (ch * sw);
                smp = sh[31:0] & ((32'd1 << sw) - 32'd1);
                if (!p_signed(d)) smp = smp ^ (32'd1 << (sw - 1));
                if (pos < sw) f[i] = smp[sw-1-pos];
            end
        end
        return f;
    endfunction

    function automatic logic [31:0] get_word(input logic [255:0] v, input int start);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[31-i] = v[start+i];
        return w;
    endfunction

    // Reference model: inputs as seen at each clock edge, frames queued per wrap.
    logic [95:0]  snd_at [3];
    logic [2:0]   mute_at;
    logic [255:0] shadow_m [3];
    logic [255:0] cur_m [3];
    logic [255:0] prev_m [3];

    always @(posedge clk_sys) begin
        snd_at[0] <= {64'd0, snd0};
        snd_at[1] <= {64'd0, snd1};
        snd_at[2] <= snd2;
        mute_at   <= mute_v;
    end

    always @(negedge clk_sys) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                shadow_m[d] <= '0;
                cur_m[d]    <= '0;
                prev_m[d]   <= '0;
            end else if (fs_v[d]) begin
                prev_m[d]   <= cur_m[d];
                cur_m[d]    <= shadow_m[d];
                shadow_m[d] <= model_frame(d, snd_at[d], mute_at[d]);
            end
        end
    end

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // From reset release: early clock edges, silence and timing of the first wrap (d0).
    task automatic first_wrap(input string tag);
        int n;
        logic nz;
        nz = 1'b0;
        tick();
        check({tag, " clk1"}, 256'({mclk_v[0], sclk_v[0]}), 256'(2'b10));
        tick();
        check({tag, " clk2"}, 256'({mclk_v[0], sclk_v[0]}), 256'(2'b01));
        n = 2;
        while (fs_v[0] !== 1'b1 && n < 1000) begin
            nz = nz | sd_v[0];
            tick();
            n++;
        end
        check({tag, " wrap cyc"}, 256'(n), 256'(128));
        check({tag, " silent"}, 256'(nz), 256'(0));
    endtask

    // Captures the frame that starts at the next frame_start and compares it to the model.
    task automatic run_frame(input int d, input string tag, input bit mute_tog,
                             output logic [255:0] sd, output logic [255:0] lr);
        logic [255:0] exp_sd, exp_lr, cur, prev;
        int n, b, cyc, ackbad, fb;
        logic sprev;
        fb = p_fb(d);
        sd = '0;
        lr = '0;
        n  = 0;
        while (fs_v[d] !== 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        check({tag, " sync"}, 256'(n >= 4000), 256'(0));
        cur    = cur_m[d];
        prev   = prev_m[d];
        b      = 0;
        cyc    = 0;
        ackbad = 0;
        sprev  = sclk_v[d];
        while (cyc < 8 * fb + 8) begin
            tick();
            cyc++;
            if (ack_v[d] !== fs_v[d]) ackbad++;
            if (fs_v[d] === 1'b1) break;
            if (sclk_v[d] && !sprev && b < fb) begin
                sd[b] = sd_v[d];
                lr[b] = lr_v[d];
                b++;
            end
            sprev = sclk_v[d];
            if (mute_tog && cyc == 20) mute_v[d] = 1'b1;
            if (mute_tog && cyc == 60) mute_v[d] = 1'b0;
        end
        exp_sd = '0;
        exp_lr = '0;
        for (int i = 0; i < fb; i++) begin
            exp_sd[i] = LJ ? cur[i] : ((i == 0) ? prev[fb-1] : cur[i-1]);
            if (p_ch(d) == 2) exp_lr[i] = (i >= p_sl(d)) ^ LJ;
            else              exp_lr[i] = LJ ? (i == 0) : (i == fb - 1);
        end
        check({tag, " sdin"}, sd, exp_sd);
        check({tag, " lrclk"}, lr, exp_lr);
        check({tag, " len"}, 256'(cyc), 256'(4 * fb));
        check({tag, " ack"}, 256'(ackbad), 256'(0));
    endtask

    initial begin
        logic [255:0] sd, lr;
        int n, falls;
        logic sp;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        mute_v   = '0;
        snd0     = 32'h0F0F_A5A5;
        snd1     = 32'h0000_8000;
        snd2     = {24'hABCDEF, 24'h123456, 24'h765432, 24'hFEDCBA};
        repeat (3) tick();
        check("reset outs", 256'({mclk_v, sclk_v, lr_v, sd_v, ack_v, fs_v}), 256'(0));
        rst = 1'b0;
        first_wrap("boot");

        // Stereo signed: zeros, then the captured sample
        run_frame(0, "d0 f1", 1'b0, sd, lr);
        check("d0 f1 zero", sd, 256'(0));
        run_frame(0, "d0 f2", 1'b0, sd, lr);
        check("d0 f2 word", 256'(get_word(sd, OFF) & ~32'(OFF)),
              256'(32'hA5A5_0F0F & ~32'(OFF)));

        for (int i = 0; i < 4; i++) begin
            snd0 = $urandom;
            run_frame(0, "d0 rnd", 1'b0, sd, lr);
        end

        // Mute sampled at one wrap only; a mid-frame pulse is ignored
        mute_v[0] = 1'b1;
        snd0 = $urandom | 32'h0101_0101;
        run_frame(0, "d0 mA", 1'b0, sd, lr);
        mute_v[0] = 1'b0;
        run_frame(0, "d0 mB", 1'b1, sd, lr);
        run_frame(0, "d0 mC", 1'b0, sd, lr);
        check("d0 muted word", 256'(get_word(sd, OFF) & ~32'(OFF)), 256'(0));
        run_frame(0, "d0 mD", 1'b0, sd, lr);

        // Unsigned conversion
        run_frame(1, "d1 f1", 1'b0, sd, lr);
        check("d1 word", 256'(get_word(sd, OFF) & ~32'(OFF)),
              256'(32'h0000_8000 & ~32'(OFF)));
        snd1 = $urandom;
        run_frame(1, "d1 f2", 1'b0, sd, lr);

        // TDM, 24-bit samples in 32-bit slots
        run_frame(2, "d2 f1", 1'b0, sd, lr);
        check("d2 slot2", 256'(get_word(sd, 64 + OFF)), 256'(32'h1234_5600));
        check("d2 sync", lr, 256'(1) << (LJ ? 0 : 127));
        snd2 = {24'($urandom), 24'h123456, 24'($urandom), 24'($urandom)};
        run_frame(2, "d2 f2", 1'b0, sd, lr);
        run_frame(2, "d2 f3", 1'b0, sd, lr);
        check("d2 slot2 b", 256'(get_word(sd, 64 + OFF)), 256'(32'h1234_5600));

        // Reset in the middle of a frame at bcnt = 9
        snd0 = $urandom | 32'h8000_8000;
        run_frame(0, "d0 pre", 1'b0, sd, lr);
        falls = 0;
        n = 0;
        while (falls < 9 && n < 1000) begin
            sp = sclk_v[0];
            tick();
            n++;
            if (sp && !sclk_v[0]) falls++;
        end
        rst = 1'b1;
        #1;
        check("midrst outs", 256'({mclk_v, sclk_v, lr_v, sd_v, ack_v, fs_v}), 256'(0));
        tick();
        tick();
        rst = 1'b0;
        first_wrap("rerun");
        run_frame(0, "d0 r1", 1'b0, sd, lr);
        check("d0 r1 zero", sd, 256'(0));
        run_frame(0, "d0 r2", 1'b0, sd, lr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
